// File: rtl/parking_gate_controller.sv
// Entry/exit barrier sequencer for a single-lane ramp sharing one occupancy counter.
// Optional gate-open timeout is compiled in with `define PARKING_GATE_TIMEOUT_EN.
module parking_gate_controller #(
    parameter int CNT_W    = 8,
    parameter int CAPACITY = 200,
    parameter int TIMEOUT  = 1000,
    parameter int TO_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_enter,
    input  logic             car_exit,
    input  logic [CNT_W-1:0] count,
    output logic             gate_in_open,
    output logic             gate_out_open,
    output logic             lot_full,
    output logic             busy,
    output logic             timeout_evt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    state_t state_r;
    state_t next_state_s;
    logic   last_dir_r;        // 1'b1 = last grant was exit
    logic   next_last_dir_s;
    logic   to_flag_r;
    logic   next_to_flag_s;
    logic   eff_entry_s;
    logic   expire_s;
    logic   open_s;
    logic   unused_cfg_s;

    assign lot_full      = (count >= CAP_C);
    assign eff_entry_s   = entry_req && !lot_full;
    assign open_s        = (state_r == OPEN_IN) || (state_r == OPEN_OUT);
    assign gate_in_open  = (state_r == OPEN_IN);
    assign gate_out_open = (state_r == OPEN_OUT);
    assign busy          = (state_r != IDLE);
    assign timeout_evt   = to_flag_r;
    assign unused_cfg_s  = ^{TIMEOUT, TO_W};

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE_C  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_r;

    // The count reaching TIMEOUT-1 on an edge means the gate has been open TIMEOUT cycles.
    assign expire_s = (to_cnt_r == TO_LAST_C);

    // Open-time counter: cleared on grant, advances while open, holds at expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= '0;
        end else if ((state_r == IDLE) && (next_state_s != IDLE)) begin
            to_cnt_r <= '0;
        end else if (open_s && !expire_s) begin
            to_cnt_r <= to_cnt_r + TO_ONE_C;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // State, arbitration history and timeout flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            last_dir_r <= 1'b1;
            to_flag_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            last_dir_r <= next_last_dir_s;
            to_flag_r  <= next_to_flag_s;
        end
    end

    // Next-state logic: round-robin grant, pass-or-timeout close, one-cycle CLOSE.
    always_comb begin
        next_state_s    = state_r;
        next_last_dir_s = last_dir_r;
        next_to_flag_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (eff_entry_s && (!exit_req || last_dir_r)) begin
                    next_state_s    = OPEN_IN;
                    next_last_dir_s = 1'b0;
                end else if (exit_req) begin
                    next_state_s    = OPEN_OUT;
                    next_last_dir_s = 1'b1;
                end else begin
                    next_state_s    = IDLE;
                end
            end
            OPEN_IN: begin
                if (car_enter) begin
                    next_state_s = CLOSE;
                end else if (expire_s) begin
                    next_state_s   = CLOSE;
                    next_to_flag_s = 1'b1;
                end else begin
                    next_state_s = OPEN_IN;
                end
            end
            OPEN_OUT: begin
                if (car_exit) begin
                    next_state_s = CLOSE;
                end else if (expire_s) begin
                    next_state_s   = CLOSE;
                    next_to_flag_s = 1'b1;
                end else begin
                    next_state_s = OPEN_OUT;
                end
            end
            CLOSE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Randomised and directed bench for parking_gate_controller against a behavioural model.
// Builds with or without PARKING_GATE_TIMEOUT_EN; TIMEOUT is overridden to 4.
module tb_parking_gate_controller;

    localparam int CAP        = 200;
    localparam int TB_TIMEOUT = 4;
`ifdef PARKING_GATE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       car_enter = 1'b0;
    logic       car_exit = 1'b0;
    logic [7:0] count = 8'd0;
    logic       gate_in_open;
    logic       gate_out_open;
    logic       lot_full;
    logic       busy;
    logic       timeout_evt;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: which gate is open (0 none, 1 entry, 2 exit), closing cycle, preference, age.
    int m_dir     = 0;
    bit m_close   = 1'b0;
    bit m_pref_in = 1'b1;
    int m_age     = 0;
    bit m_evt     = 1'b0;

    parking_gate_controller #(
        .CNT_W(8), .CAPACITY(CAP), .TIMEOUT(TB_TIMEOUT), .TO_W(16)
    ) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .car_enter(car_enter), .car_exit(car_exit), .count(count),
        .gate_in_open(gate_in_open), .gate_out_open(gate_out_open),
        .lot_full(lot_full), .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_dir = 0; m_close = 1'b0; m_pref_in = 1'b1; m_age = 0; m_evt = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit x, input bit ce, input bit cx, input int c);
        bit ee;
        ee    = e && (c < CAP);
        m_evt = 1'b0;
        if (m_dir == 0) begin
            if (m_close) m_close = 1'b0;
            else if (ee && x) m_dir = m_pref_in ? 1 : 2;
            else if (ee) m_dir = 1;
            else if (x) m_dir = 2;
            if (m_dir != 0) begin
                m_pref_in = (m_dir == 2);
                m_age = 0;
            end
        end else begin
            m_age++;
            if ((m_dir == 1 && ce) || (m_dir == 2 && cx)) begin
                m_dir = 0; m_close = 1'b1;
            end else if (TO_EN && m_age == TB_TIMEOUT) begin
                m_dir = 0; m_close = 1'b1; m_evt = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("gate_in_open", int'(gate_in_open), int'(m_dir == 1));
        chk("gate_out_open", int'(gate_out_open), int'(m_dir == 2));
        chk("busy", int'(busy), int'(m_dir != 0 || m_close));
        chk("timeout_evt", int'(timeout_evt), int'(m_evt));
        chk("lot_full", int'(lot_full), int'(int'(count) >= CAP));
    endtask

    // Drive inputs just after a falling edge, advance one cycle, check on the next falling edge.
    task automatic step(input bit e, input bit x, input bit ce, input bit cx, input int c);
        entry_req = e; exit_req = x; car_enter = ce; car_exit = cx; count = 8'(c);
        @(posedge clk);
        model_edge(e, x, ce, cx, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        entry_req = 1'b0; exit_req = 1'b0; car_enter = 1'b0; car_exit = 1'b0;
        rst = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : main
        int seq[4];
        int open_cycles;
        int evt_seen;
        bit ok;

        // Reset state, and lot_full tracking count while reset is held.
        count = 8'd5;
        repeat (2) @(negedge clk);
        model_reset();
        compare_all();
        count = 8'd200;
        #1 chk("lot_full_in_reset", int'(lot_full), 1);
        count = 8'd5;
        rst = 1'b1;

        // Single entry: open one cycle after request, CLOSE, then idle two cycles after pulse.
        step(1, 0, 0, 0, 5);
        chk("entry_open_latency", int'(gate_in_open), 1);
        step(0, 0, 0, 0, 5);
        step(0, 0, 1, 0, 5);
        chk("close_gates_low", int'(gate_in_open | gate_out_open), 0);
        chk("close_busy", int'(busy), 1);
        step(0, 0, 0, 0, 5);
        chk("idle_busy", int'(busy), 0);

        // Contended requests from reset alternate IN, OUT, IN, OUT.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            seq[g] = 0;
            for (int t = 0; t < 6 && seq[g] == 0; t++) begin
                step(1, 1, 0, 0, 5);
                seq[g] = gate_in_open ? 1 : (gate_out_open ? 2 : 0);
            end
            step(1, 1, seq[g] == 1, seq[g] == 2, 5);
        end
        for (int g = 0; g < 4; g++) chk("round_robin", seq[g], (g % 2 == 0) ? 1 : 2);

        // Full lot refuses entry but honours exit.
        do_reset();
        for (int t = 0; t < 3; t++) step(1, 0, 0, 0, 200);
        chk("full_no_entry", int'(gate_in_open | gate_out_open), 0);
        chk("full_flag", int'(lot_full), 1);
        step(1, 1, 0, 0, 200);
        chk("full_exit_open", int'(gate_out_open), 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Exit with an empty lot.
        step(0, 1, 0, 0, 0);
        chk("exit_at_zero", int'(gate_out_open), 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

`ifdef PARKING_GATE_TIMEOUT_EN
        // Gate held open for exactly TIMEOUT cycles, then a one-cycle timeout_evt.
        do_reset();
        step(1, 0, 0, 0, 5);
        open_cycles = int'(gate_in_open);
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            step(0, 0, 0, 0, 5);
            if (gate_in_open) open_cycles++;
            else ok = 1'b1;
        end
        chk("timeout_open_cycles", open_cycles, 4);
        chk("timeout_evt_pulse", int'(timeout_evt), 1);
        step(0, 0, 0, 0, 5);
        chk("timeout_evt_one_cycle", int'(timeout_evt), 0);

        // Pass pulse on the expiry edge wins over the timeout.
        step(1, 0, 0, 0, 5);
        for (int t = 0; t < 3; t++) step(0, 0, 0, 0, 5);
        step(0, 0, 1, 0, 5);
        chk("pass_beats_timeout_gate", int'(gate_in_open), 0);
        chk("pass_beats_timeout_evt", int'(timeout_evt), 0);
        step(0, 0, 0, 0, 5);
`else
        // Without the timeout the gate waits indefinitely for its pass pulse.
        do_reset();
        step(1, 0, 0, 0, 5);
        evt_seen = 0;
        for (int t = 0; t < 5000; t++) begin
            step(0, 0, 0, 0, 5);
            if (timeout_evt) evt_seen++;
        end
        chk("no_timeout_gate_open", int'(gate_in_open), 1);
        chk("no_timeout_evt", evt_seen, 0);
        step(0, 0, 1, 0, 5);
        step(0, 0, 0, 0, 5);
`endif

        // Asynchronous reset in the middle of OPEN_OUT.
        step(0, 1, 0, 0, 5);
        step(0, 1, 0, 0, 5);
        chk("pre_reset_out_open", int'(gate_out_open), 1);
        #2 rst = 1'b0;
        #1 chk("async_reset_gate_out", int'(gate_out_open), 0);
        chk("async_reset_evt", int'(timeout_evt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 5);
        chk("post_reset_idle", int'(busy), 0);

        // Random traffic, including capacity boundary and stray pulses.
        for (int t = 0; t < 3000; t++) begin
            int c;
            c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(195, 205))
                                             : int'($urandom_range(0, 255));
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
